// File: rtl/task_5_output.sv
// rtl/task_5_output.sv - byte FIFO that releases whole packets onto a valid/ready stream
//
// Optional feature macro: TASK_5_OUTPUT_PKT_CNT_EN (enables the transmitted-packet counter)
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_wr       core write strobe, one byte per cycle
//   i_data     core byte
//   i_last     written byte is the packet's final byte
//   o_full     FIFO holds DEPTH entries
//   o_overflow sticky: a write was dropped because the FIFO was full
//   o_tvalid   stream beat valid
//   o_tdata    stream beat data (FIFO head)
//   o_tlast    stream beat is the packet's final beat
//   i_tready   downstream accepts beat
//   o_busy     packet transmission in progress (send or gap)
//   o_pkt_cnt  transmitted packet count (tied to 0 when the counter is disabled)

module task_5_output #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   output logic              o_full,
   output logic              o_overflow,
   output logic              o_tvalid,
   output logic [DATA_W-1:0] o_tdata,
   output logic              o_tlast,
   input  logic              i_tready,
   output logic              o_busy,
   output logic [15:0]       o_pkt_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W:0] mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [AW:0]     pend_cnt;
   logic [DATA_W:0] head;
   logic            wr_ok;
   logic            hs;
   logic            last_hs;
   logic            pend_inc;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_ok   = i_wr && !o_full;

   // Show-ahead: the head entry is read combinationally, no read cycle needed.
   assign head     = mem[rd_ptr[AW-1:0]];
   assign o_tvalid = (state == S_SEND);
   assign o_tdata  = head[DATA_W-1:0];
   // The last bit is qualified by valid so an empty/reset FIFO never shows tlast.
   assign o_tlast  = o_tvalid && head[DATA_W];
   assign o_busy   = (state != S_IDLE);

   assign hs       = o_tvalid && i_tready;
   assign last_hs  = hs && head[DATA_W];
   assign pend_inc = wr_ok && i_last;

   // Storage array has no reset; entries are only read once written.
   always_ff @(posedge i_clk) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= {i_last, i_data};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (hs) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_overflow <= 1'b0;
      end else if (i_wr && o_full) begin
         o_overflow <= 1'b1;
      end
   end

   // Number of complete packets stored but not yet fully sent.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_cnt <= '0;
      end else begin
         case ({pend_inc, last_hs})
            2'b10:   pend_cnt <= pend_cnt + PTR_ONE;
            2'b01:   pend_cnt <= pend_cnt - PTR_ONE;
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The gap state always lasts a single cycle. When another packet is
   // already complete it proceeds straight to sending so that exactly one
   // invalid cycle separates back-to-back packets; otherwise it rests in idle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (pend_cnt != '0) begin
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (last_hs) begin
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (pend_cnt != '0) begin
               state_nxt = S_SEND;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef TASK_5_OUTPUT_PKT_CNT_EN
   logic [15:0] pkt_cnt_q;

   // One gap cycle follows every completed packet; wraps naturally at 16 bits.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pkt_cnt_q <= '0;
      end else if (state == S_GAP) begin
         pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

   assign o_pkt_cnt = pkt_cnt_q;
`else
   assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_task_5_output.sv
// tb/tb_task_5_output.sv - directed table-driven bench for task_5_output

module tb_task_5_output;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_wr;
   logic [7:0]  i_data;
   logic        i_last;
   logic        o_full;
   logic        o_overflow;
   logic        o_tvalid;
   logic [7:0]  o_tdata;
   logic        o_tlast;
   logic        i_tready;
   logic        o_busy;
   logic [15:0] o_pkt_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   task_5_output #(.DEPTH(16), .DATA_W(8)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr       (i_wr),
      .i_data     (i_data),
      .i_last     (i_last),
      .o_full     (o_full),
      .o_overflow (o_overflow),
      .o_tvalid   (o_tvalid),
      .o_tdata    (o_tdata),
      .o_tlast    (o_tlast),
      .i_tready   (i_tready),
      .o_busy     (o_busy),
      .o_pkt_cnt  (o_pkt_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic       last;
      logic       rdy;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_last;
      logic       e_busy;
      int         e_pkts;
   } vec_t;

   vec_t vec [21];

   function automatic logic [15:0] cnt_exp(input int pkts);
`ifdef TASK_5_OUTPUT_PKT_CNT_EN
      return 16'(pkts);
`else
      return 16'd0 + 16'(pkts * 0);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs, clock one edge, then sample 1 time unit after the edge.
   task automatic step(input logic wr, input logic [7:0] d, input logic last, input logic rdy);
      i_wr     = wr;
      i_data   = d;
      i_last   = last;
      i_tready = rdy;
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      i_rst = 1'b0;
   endtask

   initial begin
      int   beats;
      int   gap_cyc;
      logic [7:0] seen [4];

      i_rst = 1'b0; i_wr = 1'b0; i_data = '0; i_last = 1'b0; i_tready = 1'b0;

      //        wr    data   last  rdy  | valid data   last  busy pkts
      vec[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
      vec[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
      vec[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
      vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 0};
      vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 0};
      vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 0};
      vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0};
      vec[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1};
      vec[8]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
      vec[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
      vec[10] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
      vec[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1};
      vec[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1};
      vec[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1};
      vec[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1};
      vec[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1};
      vec[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1};
      vec[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1};
      vec[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1};
      vec[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1};
      vec[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2};

      // Reset state
      do_reset();
      chk("rst_tvalid",   o_tvalid,   1'b0);
      chk("rst_tlast",    o_tlast,    1'b0);
      chk("rst_busy",     o_busy,     1'b0);
      chk("rst_full",     o_full,     1'b0);
      chk("rst_overflow", o_overflow, 1'b0);
      chk("rst_pkt_cnt",  o_pkt_cnt,  16'd0);

      // Latency, back-to-back beats, and a 5-cycle stall on 0x55
      for (int i = 0; i < 21; i++) begin
         step(vec[i].wr, vec[i].data, vec[i].last, vec[i].rdy);
         chk($sformatf("v%0d_tvalid", i), o_tvalid, vec[i].e_valid);
         chk($sformatf("v%0d_tlast", i),  o_tlast,  vec[i].e_last);
         chk($sformatf("v%0d_busy", i),   o_busy,   vec[i].e_busy);
         chk($sformatf("v%0d_full", i),   o_full,   1'b0);
         chk($sformatf("v%0d_ovf", i),    o_overflow, 1'b0);
         chk($sformatf("v%0d_pkt_cnt", i), o_pkt_cnt, cnt_exp(vec[i].e_pkts));
         if (vec[i].e_valid) begin
            chk($sformatf("v%0d_tdata", i), o_tdata, vec[i].e_data);
         end
      end

      // Two 2-byte packets back-to-back: exactly one invalid cycle between
      do_reset();
      step(1'b1, 8'hAA, 1'b0, 1'b1);
      step(1'b1, 8'hBB, 1'b1, 1'b1);
      step(1'b1, 8'hCC, 1'b0, 1'b1);
      beats = 0; gap_cyc = 0;
      for (int c = 0; c < 20; c++) begin
         if (o_tvalid && beats < 4) begin
            seen[beats] = o_tdata;
            if (beats == 1 || beats == 3) chk($sformatf("b2b_tlast%0d", beats), o_tlast, 1'b1);
            beats++;
         end else if (!o_tvalid && beats == 2) begin
            gap_cyc++;
         end
         if (c == 0) step(1'b1, 8'hDD, 1'b1, 1'b1);
         else        step(1'b0, 8'h00, 1'b0, 1'b1);
      end
      chk("b2b_beats", beats, 4);
      chk("b2b_gap",   gap_cyc, 1);
      chk("b2b_d0", seen[0], 8'hAA);
      chk("b2b_d1", seen[1], 8'hBB);
      chk("b2b_d2", seen[2], 8'hCC);
      chk("b2b_d3", seen[3], 8'hDD);
      chk("b2b_pkt_cnt", o_pkt_cnt, cnt_exp(2));

      // Overflow: 17 writes without last at DEPTH 16
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b1);
         if (i == 14) chk("ovf_full15", o_full, 1'b0);
         if (i == 15) begin
            chk("ovf_full16", o_full, 1'b1);
            chk("ovf_ovf16",  o_overflow, 1'b0);
         end
         chk($sformatf("ovf_tvalid%0d", i), o_tvalid, 1'b0);
      end
      chk("ovf_full17", o_full, 1'b1);
      chk("ovf_ovf17",  o_overflow, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_sticky", o_overflow, 1'b1);
      chk("ovf_tvalid_idle", o_tvalid, 1'b0);
      do_reset();
      chk("ovf_rst_full", o_full, 1'b0);
      chk("ovf_rst_ovf",  o_overflow, 1'b0);

      // Reset after first beat of a 4-byte packet
      do_reset();
      step(1'b1, 8'hA0, 1'b0, 1'b0);
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 8'hA3, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("mid_first_valid", o_tvalid, 1'b1);
      chk("mid_first_data",  o_tdata,  8'hA0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("mid_second_data", o_tdata,  8'hA1);
      i_rst = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      i_rst = 1'b0;
      chk("mid_rst_tvalid", o_tvalid, 1'b0);
      chk("mid_rst_busy",   o_busy,   1'b0);
      chk("mid_rst_full",   o_full,   1'b0);
      chk("mid_rst_pend",   dut.pend_cnt, 5'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b1);
         chk($sformatf("mid_no_beat%0d", i), o_tvalid, 1'b0);
      end

      // Last-byte write coinciding with prior packet's tlast handshake
      do_reset();
      step(1'b1, 8'hE1, 1'b0, 1'b1);
      step(1'b1, 8'hE2, 1'b1, 1'b1);
      step(1'b1, 8'hF1, 1'b0, 1'b1);
      chk("coin_e1", o_tdata, 8'hE1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("coin_e2", o_tdata, 8'hE2);
      chk("coin_e2_last", o_tlast, 1'b1);
      step(1'b1, 8'hF2, 1'b1, 1'b1);
      chk("coin_gap_valid", o_tvalid, 1'b0);
      chk("coin_gap_busy",  o_busy,   1'b1);
      chk("coin_pend",      dut.pend_cnt, 5'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("coin_f1_valid", o_tvalid, 1'b1);
      chk("coin_f1",       o_tdata,  8'hF1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("coin_f2",       o_tdata,  8'hF2);
      chk("coin_f2_last",  o_tlast,  1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("coin_end_valid", o_tvalid, 1'b0);
      chk("coin_end_pend",  dut.pend_cnt, 5'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
